// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Purpose : shared defaults and types for the regfile_sb register file slice.
//           Holds the default geometry (data width, index width, read-port
//           count, scoreboard counter width) plus the register-index and
//           data-word typedefs used by decode/writeback code at that geometry.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_DEF  = 2;
  localparam int CNT_W_DEF  = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Purpose : bundles the decode/writeback side of the register file.
// Signals : ra/rd/rbusy     - packed read ports (port i at slice i)
//           we/wa/wd/wpc    - writeback write (wpc is trace only)
//           iss/ia/iss_full - decode issue into the pending-write scoreboard
//           sb_err          - sticky scoreboard underflow flag
// Modports: master = pipeline side driving requests, slave = register file.
// ---------------------------------------------------------------------------
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = NREAD_DEF
);

  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*DATA_W-1:0] rd;
  logic [NREAD-1:0]        rbusy;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [DATA_W-1:0]       wd;
  logic [31:0]             wpc;
  logic                    iss;
  logic [ADDR_W-1:0]       ia;
  logic                    iss_full;
  logic                    sb_err;

  modport master (
    output ra, we, wa, wd, wpc, iss, ia,
    input  rd, rbusy, iss_full, sb_err
  );

  modport slave (
    input  ra, we, wa, wd, wpc, iss, ia,
    output rd, rbusy, iss_full, sb_err
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Purpose : per-register count of issued-but-not-written-back instructions.
//           Drives the hazard-unit view (rbusy per read port), refuses issues
//           into a saturated counter (iss_full) and latches a sticky error
//           when a writeback arrives for a register with nothing pending.
// Ports   : clk, reset (sync, active-high)
//           iss_i/ia_i    - issue request and destination register
//           we_i/wa_i     - writeback enable and register
//           ra_i          - packed read addresses
//           iss_full_o    - counter for ia_i saturated, issue refused
//           rbusy_o       - per read port, pending count non-zero
//           sb_err_o      - sticky underflow flag
// ---------------------------------------------------------------------------
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iss_i,
  input  logic [ADDR_W-1:0]       ia_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       wa_i,
  input  logic [NREAD*ADDR_W-1:0] ra_i,
  output logic                    iss_full_o,
  output logic [NREAD-1:0]        rbusy_o,
  output logic                    sb_err_o
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic             sb_err_q, sb_err_d;
  logic             issAccept;

  // Register 0 is never counted when hardwired, so it can never saturate.
  assign iss_full_o = iss_i && (cnt_q[ia_i] == CNT_MAX);
  assign issAccept  = iss_i && !iss_full_o;
  assign sb_err_o   = sb_err_q;

  // An accepted issue and a writeback to the same register cancel out, which
  // also suppresses the underflow error for that register in that cycle.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!(ZERO_REG != 0 && r == 0)) begin
        if (issAccept && ia_i == ADDR_W'(r) && !(we_i && wa_i == ADDR_W'(r))) begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end else if (we_i && wa_i == ADDR_W'(r) && !(issAccept && ia_i == ADDR_W'(r))) begin
          if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
          end else begin
            sb_err_d = 1'b1;
          end
        end
      end
    end
  end

  // rbusy reflects the registered count only; a same-cycle writeback is
  // covered by the data bypass instead.
  always_comb begin
    rbusy_o = '0;
    for (int i = 0; i < NREAD; i++) begin
      rbusy_o[i] = (cnt_q[ra_i[i*ADDR_W +: ADDR_W]] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Purpose : parametrised register file for the pipelined CPU with NREAD
//           combinational read ports, same-cycle write-to-read bypass and a
//           pending-write scoreboard (rf_scoreboard) for the hazard unit.
// Ports   : clk   - single clock, all state on its rising edge
//           reset - synchronous, active-high, clears registers and scoreboard
//           bus   - regfile_sb_if.slave (read ports, writeback, issue, status)
// Config  : define REGFILE_WB_TRACE_EN to print one trace line per writeback
//           to a non-zero register; undefined builds contain no prints.
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [NREAD*DATA_W-1:0] rdFlat;

  // Writes to a hardwired register 0 are dropped here; the scoreboard still
  // sees the writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else if (bus.we && (bus.wa != '0 || ZERO_REG == 0)) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  // Zero register beats bypass, bypass beats storage; bypass is off in reset.
  always_comb begin
    rdFlat = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ZERO_REG != 0 && bus.ra[i*ADDR_W +: ADDR_W] == '0) begin
        rdFlat[i*DATA_W +: DATA_W] = '0;
      end else if (bus.we && !reset && bus.wa == bus.ra[i*ADDR_W +: ADDR_W]) begin
        rdFlat[i*DATA_W +: DATA_W] = bus.wd;
      end else begin
        rdFlat[i*DATA_W +: DATA_W] = mem_q[bus.ra[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.rd = rdFlat;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NREAD    (NREAD),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .iss_i      (bus.iss),
    .ia_i       (bus.ia),
    .we_i       (bus.we),
    .wa_i       (bus.wa),
    .ra_i       (bus.ra),
    .iss_full_o (bus.iss_full),
    .rbusy_o    (bus.rbusy),
    .sb_err_o   (bus.sb_err)
  );

`ifdef REGFILE_WB_TRACE_EN
  // Writeback trace: time, PC, destination and value at the committing edge.
  always_ff @(posedge clk) begin
    if (!reset && bus.we && bus.wa != '0) begin
      $display("%0t@%h: $%0d <= %h", $time, bus.wpc, bus.wa, bus.wd);
    end
  end
`else
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Purpose : self-checking bench for regfile_sb at the default geometry
//           (32-bit data, 32 registers, 2 read ports, 2-bit counters,
//           register 0 hardwired). Directed scenarios followed by random
//           traffic, all checked against a behavioural model of the
//           register contents, pending-writer counts and the error flag.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 32;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic reset;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NREAD    (NR),
    .CNT_W    (CW),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: register contents, outstanding writers, sticky error.
  logic [31:0] memModel [DEPTH];
  int          cntModel [DEPTH];
  bit          errModel;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input int a, input bit rst, input bit we,
                                          input int wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && !rst && wa == a) return wd;
    return memModel[a];
  endfunction

  // Drive one cycle of inputs, check the outputs before the edge, then
  // advance the model with the same rules the edge applies.
  task automatic applyStimulus(input bit rst, input int a0, input int a1,
                               input bit we, input int wa, input logic [31:0] wd,
                               input bit iss, input int ia, input bit doCheck);
    bit acc;
    reset   = rst;
    bus.ra  = {AW'(a1), AW'(a0)};
    bus.we  = we;
    bus.wa  = AW'(wa);
    bus.wd  = wd;
    bus.wpc = $urandom;
    bus.iss = iss;
    bus.ia  = AW'(ia);
    #1;
    if (doCheck) begin
      checkOutput("rd0", bus.rd[31:0], expRead(a0, rst, we, wa, wd));
      checkOutput("rd1", bus.rd[63:32], expRead(a1, rst, we, wa, wd));
      checkOutput("rbusy", {30'b0, bus.rbusy},
                  {30'b0, (cntModel[a1] != 0), (cntModel[a0] != 0)});
      checkOutput("iss_full", {31'b0, bus.iss_full},
                  {31'b0, (iss && cntModel[ia] == CMAX)});
      checkOutput("sb_err", {31'b0, bus.sb_err}, {31'b0, errModel});
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        memModel[r] = 32'h0;
        cntModel[r] = 0;
      end
      errModel = 1'b0;
    end else begin
      acc = iss && (cntModel[ia] < CMAX);
      if (we && wa != 0) memModel[wa] = wd;
      if (acc && ia != 0 && !(we && wa == ia)) cntModel[ia]++;
      if (we && wa != 0 && !(acc && wa == ia)) begin
        if (cntModel[wa] > 0) cntModel[wa]--;
        else errModel = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    bus.ra  = '0;
    bus.we  = 1'b0;
    bus.wa  = '0;
    bus.wd  = '0;
    bus.wpc = '0;
    bus.iss = 1'b0;
    bus.ia  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      memModel[r] = 32'h0;
      cntModel[r] = 0;
    end
    errModel = 1'b0;
    @(negedge clk);

    // Bring-up reset (state unknown beforehand), then a checked reset cycle.
    applyStimulus(1, 3, 0, 0, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 3, 0, 0, 0, 32'h0, 0, 0, 1);

    // Write with same-cycle bypass, then stored read.
    applyStimulus(0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 1);
    applyStimulus(0, 5, 0, 0, 0, 32'h0, 0, 0, 1);

    // Register 0 stays zero both during and after a write.
    applyStimulus(0, 0, 5, 1, 0, 32'h00001234, 0, 0, 1);
    applyStimulus(0, 0, 5, 0, 0, 32'h0, 0, 0, 1);

    // Saturation on register 7: three issues, a refused fourth, three writebacks.
    for (int k = 0; k < 4; k++) applyStimulus(0, 7, 0, 0, 0, 32'h0, 1, 7, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 7, 0, 1, 7, 32'h700 + k, 0, 0, 1);
    applyStimulus(0, 7, 0, 0, 0, 32'h0, 0, 0, 1);

    // Simultaneous issue and writeback on register 9 leaves the count at 1.
    applyStimulus(0, 9, 0, 0, 0, 32'h0, 1, 9, 1);
    applyStimulus(0, 9, 0, 1, 9, 32'h99, 1, 9, 1);
    applyStimulus(0, 9, 0, 0, 0, 32'h0, 0, 0, 1);

    // Underflow on register 4, pending issues on 2, then reset mid-operation.
    applyStimulus(0, 4, 2, 1, 4, 32'hCAFE0004, 0, 0, 1);
    applyStimulus(0, 4, 2, 0, 0, 32'h0, 1, 2, 1);
    applyStimulus(0, 4, 2, 0, 0, 32'h0, 1, 2, 1);
    applyStimulus(1, 4, 2, 1, 4, 32'h1111, 1, 2, 1);
    applyStimulus(0, 4, 2, 0, 0, 32'h0, 0, 0, 1);

    // Random traffic over a narrow register range so ports collide often.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 15), $urandom,
                    ($urandom_range(0, 1) == 1), $urandom_range(0, 15), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
